timer_irq_unit: RTL and testbench

TIMER_IRQ_UNIT -- requirements
Module: timer_irq_unit

---
 rtl/timer_irq_unit.sv | 114 +++++++++++
 tb/tb_timer_irq_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_irq_unit.sv
// Machine timer (mtime/mtimecmp), software interrupt bit and synchronized external
// interrupt, combined into one registered, prioritized interrupt request.
module timer_irq_unit #(
  parameter int TICK_DIV    = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_we,
  input  logic [2:0]  cfg_addr,
  input  logic [31:0] cfg_wdata,
  output logic [31:0] cfg_rdata,
  input  logic        ext_irq,
  input  logic        mstatus_mie,
  input  logic [2:0]  mie_bits,
  input  logic        irq_ack,
  output logic        interrupt,
  output logic [3:0]  irq_cause
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [3:0] CAUSE_MEI = 4'd11;
  localparam logic [3:0] CAUSE_MSI = 4'd3;
  localparam logic [3:0] CAUSE_MTI = 4'd7;

  logic [63:0]            mtime, mtimecmp;
  logic [PW-1:0]          presc;
  logic                   msip, meip;
  logic [SYNC_STAGES-1:0] sync, fill;
  logic                   sync_prev;
  logic                   tick, wr_time;
  logic                   mtip, meip_edge, next_int;
  logic [2:0]             eligible;
  logic [3:0]             next_cause;

  assign tick    = (presc == PW'(TICK_DIV - 1));
  assign wr_time = cfg_we && (cfg_addr == 3'd0 || cfg_addr == 3'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mtime    <= '0;
      presc    <= '0;
      mtimecmp <= '1;
      msip     <= 1'b0;
    end else begin
      // A software write to mtime owns the cycle and restarts the prescaler.
      if (wr_time) begin
        presc <= '0;
        if (cfg_addr == 3'd0) mtime[31:0]  <= cfg_wdata;
        else                  mtime[63:32] <= cfg_wdata;
      end else if (tick) begin
        presc <= '0;
        mtime <= mtime + 64'd1;
      end else begin
        presc <= presc + PW'(1);
      end
      if (cfg_we && cfg_addr == 3'd2) mtimecmp[31:0]  <= cfg_wdata;
      if (cfg_we && cfg_addr == 3'd3) mtimecmp[63:32] <= cfg_wdata;
      if (cfg_we && cfg_addr == 3'd4) msip            <= cfg_wdata[0];
    end
  end

  // fill marks when the sync chain holds real samples; until then the previous
  // value reads as 1 so a line held high through reset is not seen as an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync      <= '0;
      fill      <= '0;
      sync_prev <= 1'b1;
      meip      <= 1'b0;
    end else begin
      sync      <= {sync[SYNC_STAGES-2:0], ext_irq};
      fill      <= {fill[SYNC_STAGES-2:0], 1'b1};
      sync_prev <= fill[SYNC_STAGES-1] ? sync[SYNC_STAGES-1] : 1'b1;
      if (meip_edge)                            meip <= 1'b1;
      else if (irq_ack && irq_cause == CAUSE_MEI) meip <= 1'b0;
    end
  end

  assign meip_edge = fill[SYNC_STAGES-1] & sync[SYNC_STAGES-1] & ~sync_prev;
  assign mtip      = (mtime >= mtimecmp);
  assign eligible  = {meip, mtip, msip} & mie_bits;
  assign next_int  = mstatus_mie & (|eligible) & ~irq_ack;

  always_comb begin
    next_cause = 4'd0;
    if (next_int) begin
      if (eligible[2])      next_cause = CAUSE_MEI;
      else if (eligible[0]) next_cause = CAUSE_MSI;
      else                  next_cause = CAUSE_MTI;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      interrupt <= 1'b0;
      irq_cause <= 4'd0;
    end else begin
      interrupt <= next_int;
      irq_cause <= next_cause;
    end
  end

  always_comb begin
    cfg_rdata = 32'd0;
    case (cfg_addr)
      3'd0:    cfg_rdata = mtime[31:0];
      3'd1:    cfg_rdata = mtime[63:32];
      3'd2:    cfg_rdata = mtimecmp[31:0];
      3'd3:    cfg_rdata = mtimecmp[63:32];
      3'd4:    cfg_rdata = {31'd0, msip};
      default: cfg_rdata = 32'd0;
    endcase
  end
endmodule

// File: tb/tb_timer_irq_unit.sv
// Randomized + directed bench for timer_irq_unit against a cycle-level reference model.
module tb_timer_irq_unit;
  localparam int TD = 4;
  localparam int SS = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_addr = 3'd0;
  logic [31:0] cfg_wdata = 32'd0;
  logic [31:0] cfg_rdata;
  logic        ext_irq = 1'b0;
  logic        mstatus_mie = 1'b0;
  logic [2:0]  mie_bits = 3'd0;
  logic        irq_ack = 1'b0;
  logic        interrupt;
  logic [3:0]  irq_cause;

  int checks = 0;
  int errors = 0;

  timer_irq_unit #(.TICK_DIV(TD), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_rdata(cfg_rdata), .ext_irq(ext_irq), .mstatus_mie(mstatus_mie),
    .mie_bits(mie_bits), .irq_ack(irq_ack), .interrupt(interrupt), .irq_cause(irq_cause)
  );

  always #5 clk = ~clk;

  // Reference state: the architectural registers plus a history of ext samples.
  logic [63:0] m_time, m_cmp;
  int          m_cnt;
  bit          m_msip, m_meip, m_int;
  logic [3:0]  m_cause;
  bit          hist[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_time = 64'd0; m_cnt = 0; m_cmp = '1; m_msip = 0; m_meip = 0;
    m_int = 0; m_cause = 4'd0; hist.delete();
  endtask

  function automatic logic [31:0] m_rd(input logic [2:0] a);
    case (a)
      3'd0:    return m_time[31:0];
      3'd1:    return m_time[63:32];
      3'd2:    return m_cmp[31:0];
      3'd3:    return m_cmp[63:32];
      3'd4:    return {31'd0, m_msip};
      default: return 32'd0;
    endcase
  endfunction

  // One clock: check the read port, predict the next state, clock, then check outputs.
  task automatic step();
    bit [2:0] elig;
    bit n_int, n_meip, edge_seen;
    logic [3:0] n_cause;
    #1;
    chk("rdata", 64'(cfg_rdata), 64'(m_rd(cfg_addr)));
    elig    = {m_meip, (m_time >= m_cmp), m_msip} & mie_bits;
    n_int   = !irq_ack && mstatus_mie && (elig != 3'd0);
    n_cause = !n_int ? 4'd0 : elig[2] ? 4'd11 : elig[0] ? 4'd3 : 4'd7;
    // Rising edge seen SS samples late, and only once both samples postdate reset.
    hist.push_back(ext_irq);
    if (hist.size() > SS + 2) void'(hist.pop_front());
    edge_seen = (hist.size() == SS + 2) && hist[1] && !hist[0];
    n_meip = edge_seen ? 1'b1 : (irq_ack && m_cause == 4'd11) ? 1'b0 : m_meip;
    @(posedge clk);
    #1;
    if (cfg_we && cfg_addr == 3'd0)      begin m_time[31:0]  = cfg_wdata; m_cnt = 0; end
    else if (cfg_we && cfg_addr == 3'd1) begin m_time[63:32] = cfg_wdata; m_cnt = 0; end
    else if (m_cnt == TD - 1)            begin m_time = m_time + 64'd1;   m_cnt = 0; end
    else m_cnt++;
    if (cfg_we && cfg_addr == 3'd2) m_cmp[31:0]  = cfg_wdata;
    if (cfg_we && cfg_addr == 3'd3) m_cmp[63:32] = cfg_wdata;
    if (cfg_we && cfg_addr == 3'd4) m_msip = cfg_wdata[0];
    m_meip = n_meip; m_int = n_int; m_cause = n_cause;
    chk("interrupt", 64'(interrupt), 64'(m_int));
    chk("irq_cause", 64'(irq_cause), 64'(m_cause));
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic ack();
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
    cfg_addr = a;
    #1;
    chk(tag, 64'(cfg_rdata), 64'(exp));
  endtask

  task automatic ext_pulse();
    ext_irq = 1'b1;
    repeat (3) step();
    ext_irq = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    m_reset();
    #1 rst = 1'b0;
    #2;
    chk("rst_int", 64'(interrupt), 64'd0);
    chk("rst_cause", 64'(irq_cause), 64'd0);
    rd_chk("rst_cmp_lo", 3'd2, 32'hFFFF_FFFF);
    rd_chk("rst_time_lo", 3'd0, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Free-running count with the prescaler.
    cfg_addr = 3'd0;
    repeat (40) step();
    rd_chk("mtime_40", 3'd0, 32'd10);
    rd_chk("reserved", 3'd5, 32'd0);
    chk("mtip_40", 64'(interrupt), 64'd0);

    // Timer compare raises MTI, moving mtimecmp drops it.
    wr(3'd0, 32'd0);
    wr(3'd3, 32'd0);
    wr(3'd2, 32'd5);
    mstatus_mie = 1'b1; mie_bits = 3'b010;
    n = 0;
    while (!m_int && n < 60) begin step(); n++; end
    chk("mti_int", 64'(interrupt), 64'd1);
    chk("mti_cause", 64'(irq_cause), 64'd7);
    wr(3'd2, 32'd100);
    step();
    chk("mti_drop", 64'(interrupt), 64'd0);

    // External pulse latency and acknowledge.
    mie_bits = 3'b100;
    ext_pulse();
    n = 0;
    while (!m_int && n < 10) begin step(); n++; end
    chk("mei_int", 64'(interrupt), 64'd1);
    chk("mei_cause", 64'(irq_cause), 64'd11);
    chk("mei_latency", 64'((3 + n) <= SS + 2), 64'd1);
    ack();
    chk("mei_ack", 64'(interrupt), 64'd0);
    repeat (5) step();
    chk("mei_stay0", 64'(interrupt), 64'd0);

    // Priority MEI > MSI > MTI.
    mie_bits = 3'b111;
    wr(3'd4, 32'd1);
    wr(3'd2, 32'd0);
    ext_pulse();
    n = 0;
    while (m_cause != 4'd11 && n < 10) begin step(); n++; end
    chk("prio_mei", 64'(irq_cause), 64'd11);
    ack();
    chk("prio_mask", 64'(interrupt), 64'd0);
    step();
    chk("prio_msi", 64'(irq_cause), 64'd3);
    wr(3'd4, 32'd0);
    step();
    chk("prio_mti", 64'(irq_cause), 64'd7);

    // 64-bit wrap; MTIP with mtimecmp=0 holds.
    mie_bits = 3'b000;
    wr(3'd1, 32'hFFFF_FFFF);
    wr(3'd0, 32'hFFFF_FFFF);
    repeat (3) step();
    rd_chk("wrap_pre_hi", 3'd1, 32'hFFFF_FFFF);
    step();
    rd_chk("wrap_lo", 3'd0, 32'd0);
    rd_chk("wrap_hi", 3'd1, 32'd0);
    mie_bits = 3'b010;
    repeat (2) step();
    chk("wrap_mtip", 64'(interrupt), 64'd1);

    // Global enable gating.
    mstatus_mie = 1'b0; mie_bits = 3'b111;
    wr(3'd4, 32'd1);
    ext_pulse();
    repeat (4) step();
    chk("gate_int", 64'(interrupt), 64'd0);
    chk("gate_cause", 64'(irq_cause), 64'd0);
    mstatus_mie = 1'b1;
    step();
    chk("gate_int_on", 64'(interrupt), 64'd1);
    chk("gate_cause_on", 64'(irq_cause), 64'd11);
    ack();
    wr(3'd4, 32'd0);
    wr(3'd3, 32'hFFFF_FFFF);

    // Reset mid-run with ext_irq held high across release.
    mie_bits = 3'b100; ext_irq = 1'b1;
    step();
    #2 rst = 1'b0;
    cfg_addr = 3'd2;
    #1;
    chk("mrst_int", 64'(interrupt), 64'd0);
    chk("mrst_cmp", 64'(cfg_rdata), 64'hFFFF_FFFF);
    m_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (8) step();
    chk("held_high", 64'(interrupt), 64'd0);
    rd_chk("restart_cnt", 3'd0, 32'd2);
    ext_irq = 1'b0;
    repeat (3) step();
    ext_irq = 1'b1;
    n = 0;
    while (!m_int && n < 10) begin step(); n++; end
    chk("rearm_int", 64'(interrupt), 64'd1);
    chk("rearm_cause", 64'(irq_cause), 64'd11);
    ack();

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      cfg_we   = ($urandom_range(0, 7) == 0);
      cfg_addr = 3'($urandom_range(0, 7));
      case (cfg_addr)
        3'd0:    cfg_wdata = 32'($urandom_range(0, 60));
        3'd1:    cfg_wdata = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : 32'd0;
        3'd2:    cfg_wdata = m_time[31:0] + 32'($urandom_range(0, 12)) - 32'd4;
        3'd3:    cfg_wdata = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : m_time[63:32];
        default: cfg_wdata = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) ext_irq = ~ext_irq;
      if ($urandom_range(0, 31) == 0) mie_bits = 3'($urandom);
      mstatus_mie = ($urandom_range(0, 9) != 0);
      irq_ack = m_int ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      step();
    end
    cfg_we = 1'b0; irq_ack = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
